// File: rtl/mem_pkg.sv
// Shared memory-bus types: access width encoding, responder FSM states,
// the latched request payload and the alignment check.
package mem_pkg;

  // funct3[1:0] encoding of the access width
  typedef enum logic [1:0] {
    BITS8     = 2'd0,
    BITS16    = 2'd1,
    BITS32    = 2'd2,
    BITS_RSVD = 2'd3
  } mem_width_e;

  // Responder FSM states
  typedef logic [1:0] resp_state_t;
  localparam resp_state_t ST_IDLE = 2'd0;
  localparam resp_state_t ST_WAIT = 2'd1;
  localparam resp_state_t ST_RESP = 2'd2;

  // Request payload as latched at accept
  typedef struct packed {
    logic       write;
    mem_width_e width;
    logic       sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // True when the access does not sit naturally aligned inside one word
  function automatic logic is_misaligned(input mem_width_e width, input logic [1:0] lane);
    logic mis;
    case (width)
      BITS8:   mis = 1'b0;
      BITS16:  mis = lane[0];
      BITS32:  mis = (lane != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit storage word and a narrow access.
// Ports:
//   rd_word  in  32  storage word being read
//   lane     in  2   byte offset within the word
//   width    in  2   access width
//   sign_ext in  1   sign-extend narrow reads
//   wdata    in  32  store data, low bits significant
//   rd_data  out 32  extended load data
//   wr_be    out 4   byte enables for the store
//   wr_data  out 32  store data moved onto its lanes
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  mem_width_e  width,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data
);

  logic [31:0] shifted;

  // Read: bring the addressed lane down to bit 0, then extend.
  // Write: move the low data bits up to the addressed lane.
  always_comb begin
    shifted = rd_word >> {lane, 3'b000};
    rd_data = rd_word;
    wr_be   = 4'b1111;
    wr_data = wdata;
    case (width)
      BITS8: begin
        rd_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        wr_be   = 4'b0001 << lane;
        wr_data = wdata << {lane, 3'b000};
      end
      BITS16: begin
        rd_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        wr_be   = 4'b0011 << lane;
        wr_data = wdata << {lane, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: one request at a time over valid/ready, a
// programmable number of wait states, then a held response.
// Optional macro MEM_RESP_ERR_EN: flag misaligned / out-of-range accesses
// with rsp_error instead of wrapping and force-aligning them.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   req_valid/req_ready       request handshake
//   req_write, req_width,
//   req_signed, req_addr,
//   req_wdata                 request fields
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_error      response payload
module mem_bus_responder
  import mem_pkg::*;
#(
  parameter int unsigned WORDS       = 16383,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = 4;

  resp_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mem_req_t         req_q, req_nxt;
  logic             req_ready_nxt, rsp_valid_nxt, rsp_error_nxt;
  logic [31:0]      rsp_rdata_nxt;

  logic [31:0]      mem [WORDS];
  logic [29:0]      word_addr;
  logic [IDX_W-1:0] mem_idx;
  logic [1:0]       acc_lane;
  mem_width_e       acc_width;
  logic             acc_err;
  logic             acc_go;
  logic             wr_en;
  logic [31:0]      rd_data, wr_data;
  logic [3:0]       wr_be;

  assign word_addr = req_q.addr[31:2];

  // Access decode from the latched request
  always_comb begin
`ifdef MEM_RESP_ERR_EN
    acc_err   = is_misaligned(req_q.width, req_q.addr[1:0]) || (32'(word_addr) >= WORDS);
    mem_idx   = IDX_W'(word_addr);
    acc_lane  = req_q.addr[1:0];
    acc_width = req_q.width;
`else
    // No error reporting: wrap the index and drop the misaligned low bits
    acc_err   = 1'b0;
    mem_idx   = IDX_W'(32'(word_addr) % WORDS);
    acc_lane  = 2'b00;
    acc_width = req_q.width;
    case (req_q.width)
      BITS8:     acc_lane = req_q.addr[1:0];
      BITS16:    acc_lane = {req_q.addr[1], 1'b0};
      BITS_RSVD: acc_width = BITS32;
      default:   ;
    endcase
`endif
  end

  mem_lane_align u_align (
    .rd_word  (mem[mem_idx]),
    .lane     (acc_lane),
    .width    (acc_width),
    .sign_ext (req_q.sign_ext),
    .wdata    (req_q.wdata),
    .rd_data  (rd_data),
    .wr_be    (wr_be),
    .wr_data  (wr_data)
  );

  // The access happens on the first edge spent in RESP
  assign acc_go = (state == ST_RESP) && !rsp_valid;
  assign wr_en  = acc_go && req_q.write && !acc_err;

  // Next-state and output logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    req_nxt       = req_q;
    req_ready_nxt = 1'b0;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_error_nxt = rsp_error;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          req_nxt.write    = req_write;
          req_nxt.width    = mem_width_e'(req_width);
          req_nxt.sign_ext = req_signed;
          req_nxt.addr     = req_addr;
          req_nxt.wdata    = req_wdata;
          cnt_nxt          = CNT_W'(WAIT_CYCLES);
          state_nxt        = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (!rsp_valid) begin
          rsp_valid_nxt = 1'b1;
          rsp_error_nxt = acc_err;
          rsp_rdata_nxt = (req_q.write || acc_err) ? 32'h0 : rd_data;
        end else if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rsp_error_nxt = 1'b0;
          rsp_rdata_nxt = 32'h0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    req_ready_nxt = (state_nxt == ST_IDLE);
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_q     <= req_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_error <= rsp_error_nxt;
    end
  end

  // Storage: not reset, byte-lane writes
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder (WAIT_CYCLES=1 main instance,
// WAIT_CYCLES=0 second instance for latency). Honors MEM_RESP_ERR_EN.
module tb_mem_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write, b_req_signed;
  logic [1:0]  b_req_width;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_error;
  logic [31:0] b_rsp_rdata;

  mem_bus_responder #(.WORDS(16383), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  mem_bus_responder #(.WORDS(16383), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_width(b_req_width), .req_signed(b_req_signed), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request and return #1 after the accepting edge
  task automatic issue(input logic w, input logic [1:0] wd, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_width = wd; req_signed = s;
    req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response, optionally hold it, then take it
  task automatic finish_rsp(input int hold, input logic [31:0] exp_rd,
                            output logic [31:0] rd, output logic e, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    check("ready_while_valid", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rd = rsp_rdata;
    e  = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_cleared", 32'(rsp_valid), 32'd0);
  endtask

  task automatic xact(input string tag, input logic w, input logic [1:0] wd, input logic s,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_e);
    logic [31:0] rd;
    logic        e;
    int          lat;
    issue(w, wd, s, a, d);
    finish_rsp(0, 32'h0, rd, e, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic xact_b(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    int n = 0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = w; b_req_width = 2'd2; b_req_signed = 1'b0;
    b_req_addr = a; b_req_wdata = d;
    while (!b_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_req_ready) check("b_accept_timeout", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    lat = 0;
    while (!b_rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = b_rsp_rdata;
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_width = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_width = 2'd0; b_req_signed = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 32'h0; b_rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: reset mid-WAIT abandons a pending store
    xact("pre_sw", 1'b1, 2'd2, 1'b0, 32'h100, 32'hcafef00d, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'h0);
    check("midrst_rsp_error", 32'(rsp_error), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    xact("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hcafef00d, 1'b0);

    // 2: word store latency and read-back
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hdeadbeef);
    finish_rsp(0, 32'h0, rd, e, lat);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_rdata", rd, 32'h0);
    xact("lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hdeadbeef, 1'b0);

    // 3: byte store and signed/unsigned byte loads
    xact("sb_101", 1'b1, 2'd0, 1'b0, 32'h101, 32'h12345680, 32'h0, 1'b0);
    xact("lb_101", 1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'hffffff80, 1'b0);
    xact("lbu_101", 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h00000080, 1'b0);
    xact("lw_after_sb", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hdead80ef, 1'b0);

    // 4: halfword loads and store in the upper half
    xact("sw_8001", 1'b1, 2'd2, 1'b0, 32'h100, 32'h80011234, 32'h0, 1'b0);
    xact("lh_102", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'hffff8001, 1'b0);
    xact("lhu_102", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h00008001, 1'b0);
    xact("sh_102", 1'b1, 2'd1, 1'b0, 32'h102, 32'h00ab7fff, 32'h0, 1'b0);
    xact("lh_102b", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h00007fff, 1'b0);
    xact("lw_after_sh", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h7fff1234, 1'b0);
    xact("lb_103", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h0000007f, 1'b0);

    // 5: response held while rsp_ready low; zero-wait instance latency
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    finish_rsp(5, 32'h7fff1234, rd, e, lat);
    check("hold_lw_rdata", rd, 32'h7fff1234);
    xact_b(1'b1, 32'h40, 32'h13579bdf, rd, lat);
    check("w0_sw_latency", 32'(lat), 32'd1);
    check("w0_sw_rdata", rd, 32'h0);
    xact_b(1'b0, 32'h40, 32'h0, rd, lat);
    check("w0_lw_latency", 32'(lat), 32'd1);
    check("w0_lw_rdata", rd, 32'h13579bdf);

    // 6: misaligned / out-of-range handling
`ifdef MEM_RESP_ERR_EN
    xact("err_lw_102", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1);
    xact("err_sw_103", 1'b1, 2'd2, 1'b0, 32'h103, 32'hffffffff, 32'h0, 1'b1);
    xact("err_sh_101", 1'b1, 2'd1, 1'b0, 32'h101, 32'hffffffff, 32'h0, 1'b1);
    xact("lw_unchanged", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h7fff1234, 1'b0);
    xact("err_range", 1'b0, 2'd2, 1'b0, 32'h10000, 32'h0, 32'h0, 1'b1);
    xact("err_w3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
`else
    xact("noerr_lw_102", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h7fff1234, 1'b0);
    xact("noerr_w3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h7fff1234, 1'b0);
    xact("noerr_sh_101", 1'b1, 2'd1, 1'b0, 32'h101, 32'h0000beef, 32'h0, 1'b0);
    xact("noerr_lw_sh", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h7fffbeef, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
